simple_processor_top: RTL and testbench
=======================================

// Module: simple_processor_top
// PURPOSE
// - Multi-cycle 9-bit processor: eight GPRs R0-R7, accumulator A, result G, add/sub ALU, shared 9-bit bus.
// - Instructions (mv, mvi, add, sub) enter on DIN while Run is high. The internal bus is exported for observation.
// - Done pulses on the final step of each instruction. Top-level datapath plus control, no memory interface.
// PARAMETERS
// - N       9   datapath / instruction width (fixed at 9; encoding depends on it)
// PORTS
// - Clock   in   1   single system clock, rising edge
// - Resetn  in   1   asynchronous, active-low reset
// - Run     in   1   start request, sampled only in step T0
// - DIN     in   9   instruction word in T0; immediate data during mvi step T1
// - Bus     out  9   internal bus value, combinational from mux
// - Done    out  1   high during final step of an instruction (combinational)
// BEHAVIOUR
// - Instruction format (IR): opcode=IR[2:0], X=IR[5:3] (dest), Y=IR[8:6] (source).
// - Opcodes:
//   - 000 mv   Rx<=Ry
//   - 001 mvi  Rx<=DIN (next word)
//   - 010 add  Rx<=Rx+Ry
//   - 011 sub  Rx<=Rx-Ry
//   - 100-111  no-op
// - Step counter T0..T3 (2-bit). Run is sampled only in T0.
//   - T0 with Run=1: at the clock edge, IR<=DIN and step->T1.
//   - T0 with Run=0: stay in T0.
//   - From T1 onward the counter advances every clock. In the Done step it returns to T0.
// - Per-step control (unlisted signals are 0):
//   - mv   T1: Bus=Ry, load Rx, Done=1
//   - mvi  T1: Bus=DIN, load Rx, Done=1
//   - add/sub T1: Bus=Rx, load A
//   - add/sub T2: Bus=Ry, load G with A+Bus (add) or A-Bus (sub)
//   - add/sub T3: Bus=G, load Rx, Done=1
//   - no-op T1: Done=1, no register writes
// - Latency:
//   - mv/mvi: 2 cycles (T0 fetch + T1).
//   - add/sub: 4 cycles.
//   - Next fetch can occur in the cycle after Done.
// - Arithmetic is modulo 2^9. No carry or overflow flags. Sub is two's complement.
// - Bus mux priority: one-hot select of {R0..R7, G, DIN}. With no select asserted (T0, no-op), Bus=9'h000.
// - Register writes happen on the rising edge when their enable is high. X==Y is legal: add R1,R1 doubles R1.
// - Reset (Resetn=0, async):
//   - Step=T0; IR, A, G and R0-R7 all clear to 0.
//   - Outputs: Bus=0, Done=0.
//   - Reset mid-instruction aborts it with no partial write after reset asserts.
// - Run dropping after T0 does not stall an instruction already in progress.
// - DIN is sampled only in T0 (when Run=1) and in mvi T1.
// STRUCTURE
// - Shared package: opcode localparams (OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011) and the step encoding T0..T3.
// - Sub-module regn: N-bit register with load enable and async active-low clear.
//   - Instantiated for R0-R7, A, G and IR.
// - Bus mux, adder/subtractor, X/Y 3-to-8 decoders and the control FSM live in the top.
// TESTING
// - Reset: hold Resetn=0 two cycles -> Bus=0, Done=0; a later mv R0,R1 shows 0 on Bus.
// - mvi: DIN=9'b011000001 in T0, then 9'h1CF in T1.
//   - Required: Done=1 and Bus=9'h1CF in T1; R0=9'h1CF afterwards.
//   - Repeat for R1-R7 with distinct immediates.
// - mv: after R2=9'h1FF, issue mv R5,R2 (9'b010101000).
//   - Required: Bus=9'h1FF and Done in T1; R5=9'h1FF.
// - add wrap: R0=9'h1CF, R1=9'h155, issue add R0,R1 (9'b001000010).
//   - Required: T3 Bus=9'h124, Done=1; R0=9'h124 (mod 512).
// - sub: R3=9'h005, R4=9'h007, issue sub R3,R4 -> R3=9'h1FE; also check sub R3,R3 -> 0.
// - Run/reset edges:
//   - Run=0 in T0 -> no fetch and no Done.
//   - Resetn pulsed in add T2 -> step=T0, Rx unchanged at 0, no Done.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// Shared definitions for the simple 9-bit multi-cycle processor.
// Holds the datapath width, the opcode values, the step-counter encoding
// and a small 3-to-8 decoder helper used for register selection.
package simple_processor_pkg;

  localparam int N = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  // One-hot decode of a 3-bit register index.
  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    dec3to8 = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/simple_processor_regn.sv
// regn: N-bit register with load enable and asynchronous active-low clear.
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low clear
//   load   - when high, q takes d on the rising edge
//   d      - next value
//   q      - stored value
module regn
  import simple_processor_pkg::*;
#(
  parameter int W = N
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Storage with load enable; cleared asynchronously by Resetn.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/simple_processor.sv
// simple_processor_top: multi-cycle 9-bit processor with eight GPRs (R0-R7),
// accumulator A, result register G and an add/sub ALU on a shared bus.
// Instructions are fetched from DIN in step T0 while Run is high; mvi takes
// its immediate from DIN in step T1.
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset
//   Run    - start request, sampled only in T0
//   DIN    - instruction word (T0) or immediate (mvi T1)
//   Bus    - internal bus value (combinational)
//   Done   - high during the final step of an instruction (combinational)
module simple_processor_top
  import simple_processor_pkg::*;
(
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  output logic [N-1:0] Bus,
  output logic         Done
);

  step_t        step_r;
  step_t        step_next_s;

  logic [N-1:0] ir_q_s;
  logic [N-1:0] a_q_s;
  logic [N-1:0] g_q_s;
  logic [N-1:0] r_q_s [0:7];
  logic [N-1:0] bus_s;
  logic [N-1:0] alu_s;

  logic [2:0]   op_s;
  logic [7:0]   xreg_s;
  logic [7:0]   yreg_s;

  logic         ir_load_s;
  logic [7:0]   rin_s;
  logic         ain_s;
  logic         gin_s;
  logic [7:0]   sel_r_s;
  logic         sel_g_s;
  logic         sel_din_s;
  logic         sub_s;
  logic         done_s;

  assign op_s      = ir_q_s[2:0];
  assign xreg_s    = dec3to8(ir_q_s[5:3]);
  assign yreg_s    = dec3to8(ir_q_s[8:6]);
  assign ir_load_s = (step_r == T0) && Run;

  // Step counter state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_r <= T0;
    end else begin
      step_r <= step_next_s;
    end
  end

  // Per-step control decode and next-step selection.
  always_comb begin
    step_next_s = step_r;
    rin_s       = 8'h00;
    ain_s       = 1'b0;
    gin_s       = 1'b0;
    sel_r_s     = 8'h00;
    sel_g_s     = 1'b0;
    sel_din_s   = 1'b0;
    sub_s       = 1'b0;
    done_s      = 1'b0;

    case (step_r)
      T0: begin
        if (Run) begin
          step_next_s = T1;
        end else begin
          step_next_s = T0;
        end
      end
      T1: begin
        step_next_s = T2;
        case (op_s)
          OP_MV: begin
            sel_r_s = yreg_s;
            rin_s   = xreg_s;
            done_s  = 1'b1;
          end
          OP_MVI: begin
            sel_din_s = 1'b1;
            rin_s     = xreg_s;
            done_s    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_r_s = xreg_s;
            ain_s   = 1'b1;
          end
          default: begin
            done_s = 1'b1;
          end
        endcase
      end
      T2: begin
        step_next_s = T3;
        if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
          sel_r_s = yreg_s;
          gin_s   = 1'b1;
          sub_s   = (op_s == OP_SUB);
        end else begin
          // Unreachable for single-step opcodes; return to fetch safely.
          done_s = 1'b1;
        end
      end
      T3: begin
        step_next_s = T0;
        if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
          sel_g_s = 1'b1;
          rin_s   = xreg_s;
          done_s  = 1'b1;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        step_next_s = T0;
      end
    endcase

    // The Done step always hands control back to fetch.
    if (done_s) begin
      step_next_s = T0;
    end else begin
      step_next_s = step_next_s;
    end
  end

  // Bus mux: R0 has highest priority, then R1..R7, then G, then DIN.
  always_comb begin
    bus_s = 9'h000;
    if (|sel_r_s) begin
      for (int i = 7; i >= 0; i--) begin
        if (sel_r_s[i]) begin
          bus_s = r_q_s[i];
        end else begin
          bus_s = bus_s;
        end
      end
    end else if (sel_g_s) begin
      bus_s = g_q_s;
    end else if (sel_din_s) begin
      bus_s = DIN;
    end else begin
      bus_s = 9'h000;
    end
  end

  // Add/subtract unit; result wraps modulo 2^N.
  always_comb begin
    if (sub_s) begin
      alu_s = a_q_s - bus_s;
    end else begin
      alu_s = a_q_s + bus_s;
    end
  end

  regn #(.W(N)) u_ir (
    .Clock (Clock),
    .Resetn(Resetn),
    .load  (ir_load_s),
    .d     (DIN),
    .q     (ir_q_s)
  );

  regn #(.W(N)) u_a (
    .Clock (Clock),
    .Resetn(Resetn),
    .load  (ain_s),
    .d     (bus_s),
    .q     (a_q_s)
  );

  regn #(.W(N)) u_g (
    .Clock (Clock),
    .Resetn(Resetn),
    .load  (gin_s),
    .d     (alu_s),
    .q     (g_q_s)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_gpr
    regn #(.W(N)) u_r (
      .Clock (Clock),
      .Resetn(Resetn),
      .load  (rin_s[gi]),
      .d     (bus_s),
      .q     (r_q_s[gi])
    );
  end

  assign Bus  = bus_s;
  assign Done = done_s;

endmodule

// File: tb/tb_simple_processor_top.sv
// Self-checking bench for simple_processor_top: directed cases plus a random
// instruction stream checked against an architectural register-file model.
module tb_simple_processor_top;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] DIN;
  logic [8:0] Bus;
  logic       Done;

  int tests_run;
  int tests_failed;

  // Architectural model: register contents after each completed instruction.
  logic [8:0] m [8];

  simple_processor_top dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .DIN   (DIN),
    .Bus   (Bus),
    .Done  (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int x, input int y);
    logic [8:0] w;
    w = {y[2:0], x[2:0], op[2:0]};
    return w;
  endfunction

  // Run one instruction, checking Bus/Done in every step against the model.
  task automatic exec(input logic [8:0] instr, input logic [8:0] imm);
    int op, x, y;
    logic [8:0] res;
    op = int'(instr[2:0]);
    x  = int'(instr[5:3]);
    y  = int'(instr[8:6]);
    @(negedge Clock);
    Run = 1'b1;
    DIN = instr;
    #1;
    check_eq("t0_done", {8'h00, Done}, 9'h000);
    check_eq("t0_bus", Bus, 9'h000);
    @(negedge Clock);
    Run = 1'($urandom % 2);
    DIN = (op == 1) ? imm : 9'($urandom);
    #1;
    case (op)
      0: begin
        check_eq("mv_bus", Bus, m[y]);
        check_eq("mv_done", {8'h00, Done}, 9'h001);
        m[x] = m[y];
      end
      1: begin
        check_eq("mvi_bus", Bus, imm);
        check_eq("mvi_done", {8'h00, Done}, 9'h001);
        m[x] = imm;
      end
      2, 3: begin
        res = (op == 2) ? 9'(m[x] + m[y]) : 9'(m[x] - m[y]);
        check_eq("alu_t1_bus", Bus, m[x]);
        check_eq("alu_t1_done", {8'h00, Done}, 9'h000);
        @(negedge Clock);
        DIN = 9'($urandom);
        #1;
        check_eq("alu_t2_bus", Bus, m[y]);
        check_eq("alu_t2_done", {8'h00, Done}, 9'h000);
        @(negedge Clock);
        #1;
        check_eq("alu_t3_bus", Bus, res);
        check_eq("alu_t3_done", {8'h00, Done}, 9'h001);
        m[x] = res;
      end
      default: begin
        check_eq("nop_bus", Bus, 9'h000);
        check_eq("nop_done", {8'h00, Done}, 9'h001);
      end
    endcase
    Run = 1'b0;
  endtask

  // Observe Rk via "mv Rk,Rk" and compare to an explicit value.
  task automatic read_reg(input int k, input logic [8:0] exp);
    @(negedge Clock);
    Run = 1'b1;
    DIN = enc(0, k, k);
    @(negedge Clock);
    Run = 1'b0;
    #1;
    check_eq($sformatf("read_r%0d", k), Bus, exp);
    check_eq("read_done", {8'h00, Done}, 9'h001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] imms [8];
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 8; i++) m[i] = 9'h000;
    Run    = 1'b0;
    DIN    = 9'h1FF;
    Resetn = 1'b0;

    // Reset held two cycles.
    repeat (2) @(negedge Clock);
    #1;
    check_eq("rst_bus", Bus, 9'h000);
    check_eq("rst_done", {8'h00, Done}, 9'h000);
    Resetn = 1'b1;
    exec(9'b001_000_000, 9'h000); // mv R0,R1 -> Bus 0
    read_reg(0, 9'h000);

    // mvi into every register with distinct immediates.
    exec(9'b011000001, 9'h1CF);
    read_reg(0, 9'h1CF);
    imms = '{9'h1CF, 9'h155, 9'h1FF, 9'h005, 9'h007, 9'h0A3, 9'h13C, 9'h066};
    for (int k = 1; k < 8; k++) exec(enc(1, k, 0), imms[k]);
    for (int k = 0; k < 8; k++) read_reg(k, imms[k]);

    // mv R5,R2 with R2 = 0x1FF.
    exec(9'b010101000, 9'h000);
    read_reg(5, 9'h1FF);

    // add R0,R1 wraps: 0x1CF + 0x155 = 0x124.
    exec(9'b001000010, 9'h000);
    read_reg(0, 9'h124);

    // sub R3,R4: 5 - 7 = 0x1FE; then sub R3,R3 = 0.
    exec(enc(3, 3, 4), 9'h000);
    read_reg(3, 9'h1FE);
    exec(enc(3, 3, 3), 9'h000);
    read_reg(3, 9'h000);

    // add R1,R1 doubles R1: 0x155*2 mod 512 = 0x0AA.
    exec(enc(2, 1, 1), 9'h000);
    read_reg(1, 9'h0AA);

    // Run low in T0: no fetch, no Done.
    @(negedge Clock);
    Run = 1'b0;
    DIN = enc(1, 2, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #1;
      check_eq("idle_done", {8'h00, Done}, 9'h000);
      check_eq("idle_bus", Bus, 9'h000);
    end
    read_reg(2, 9'h1FF);

    // Random instruction stream against the model.
    for (int n = 0; n < 300; n++) begin
      exec(9'($urandom), 9'($urandom));
    end
    for (int k = 0; k < 8; k++) read_reg(k, m[k]);

    // Reset asserted during add T2 aborts the instruction.
    exec(enc(1, 6, 0), 9'h0AA);
    exec(enc(1, 2, 0), 9'h000);
    @(negedge Clock);
    Run = 1'b1;
    DIN = enc(2, 2, 6);
    @(negedge Clock);
    Run = 1'b0;
    @(negedge Clock);
    #1;
    check_eq("pre_rst_t2_bus", Bus, 9'h0AA);
    Resetn = 1'b0;
    #1;
    check_eq("midrst_done", {8'h00, Done}, 9'h000);
    check_eq("midrst_bus", Bus, 9'h000);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = 9'h000;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #1;
      check_eq("post_rst_done", {8'h00, Done}, 9'h000);
    end
    read_reg(2, 9'h000);
    read_reg(6, 9'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
